rvm_operand_fetch: RTL

//  Operand-fetch stage directly upstream of the 32-bit add/sub unit. Takes a decoded

---
 rtl/rvm_operand_fetch_pkg.sv | 19 +
 rtl/rvm_opfwd_mux.sv | 21 ++
 rtl/rvm_operand_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rvm_operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage: adder op encodings and the
// fetch FSM state encoding.
package rvm_operand_fetch_pkg;

    // Adder operation encodings
    localparam logic [2:0] RVM_ARITH_NOP = 3'b000;
    localparam logic [2:0] RVM_ARITH_ADD = 3'b001;
    localparam logic [2:0] RVM_ARITH_SUB = 3'b010;

    // Fetch FSM states, one register-file read per RS1/RS2 cycle
    typedef enum logic [2:0] {
        RVM_OPF_IDLE = 3'd0,
        RVM_OPF_RS1  = 3'd1,
        RVM_OPF_RS2  = 3'd2,
        RVM_OPF_CAP  = 3'd3,
        RVM_OPF_OUT  = 3'd4
    } opf_state_t;

endpackage

// File: rtl/rvm_opfwd_mux.sv
// Per-operand write-back bypass: picks wb_data over rf_rdata when the write
// targets the same non-zero register being read and forwarding is enabled.
module rvm_opfwd_mux #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 fwd_en,
    input  logic [RF_ADDR_W-1:0] idx,
    input  logic                 wb_en,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic [XLEN-1:0]      data
);

    logic hit;

    assign hit  = fwd_en && wb_en && (wb_addr == idx) && (idx != '0);
    assign data = hit ? wb_data : rf_rdata;

endmodule

// File: rtl/rvm_operand_fetch.sv
// Operand-fetch stage feeding the add/sub unit. Reads rs1 then rs2 over one
// synchronous register-file port, muxes in pc/imm, and presents lhs/rhs/op
// under valid/ready. op is forced to NOP whenever operands are not presented.
// Optional build macro RVM_OPFWD_EN enables write-back bypass on both reads;
// without it the wb_* ports are ignored.
module rvm_operand_fetch
    import rvm_operand_fetch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RF_ADDR_W-1:0] in_rs1,
    input  logic [RF_ADDR_W-1:0] in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 in_use_imm,
    input  logic                 in_use_pc,
    input  logic [2:0]           in_op,
    output logic                 rf_rden,
    output logic [RF_ADDR_W-1:0] rf_addr,
    input  logic [XLEN-1:0]      rf_rdata,
    input  logic                 wb_en,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic [XLEN-1:0]      lhs,
    output logic [XLEN-1:0]      rhs,
    output logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready
);

    opf_state_t           state, state_next;
    logic [RF_ADDR_W-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0]      imm_q, pc_q;
    logic                 use_imm_q, use_pc_q;
    logic [2:0]           op_q;
    logic                 accept;
    logic                 fwd_en;
    logic [XLEN-1:0]      rs1_data, rs2_data;

`ifdef RVM_OPFWD_EN
    assign fwd_en = 1'b1;
`else
    assign fwd_en = 1'b0;
`endif

    rvm_opfwd_mux #(.XLEN(XLEN), .RF_ADDR_W(RF_ADDR_W)) u_fwd_rs1 (
        .fwd_en   (fwd_en),
        .idx      (rs1_q),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rf_rdata (rf_rdata),
        .data     (rs1_data)
    );

    rvm_opfwd_mux #(.XLEN(XLEN), .RF_ADDR_W(RF_ADDR_W)) u_fwd_rs2 (
        .fwd_en   (fwd_en),
        .idx      (rs2_q),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rf_rdata (rf_rdata),
        .data     (rs2_data)
    );

    assign in_ready  = (state == RVM_OPF_IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == RVM_OPF_OUT);
    assign op        = out_valid ? op_q : RVM_ARITH_NOP;

    // Next-state and register-file read control
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        rf_rden    = 1'b0;
        rf_addr    = '0;
        unique case (state)
            RVM_OPF_IDLE: if (in_valid) state_next = RVM_OPF_RS1;
            RVM_OPF_RS1: begin
                rf_addr    = rs1_q;
                rf_rden    = !use_pc_q && (rs1_q != '0);
                state_next = RVM_OPF_RS2;
            end
            RVM_OPF_RS2: begin
                rf_addr    = rs2_q;
                rf_rden    = !use_imm_q && (rs2_q != '0);
                state_next = RVM_OPF_CAP;
            end
            RVM_OPF_CAP:  state_next = RVM_OPF_OUT;
            RVM_OPF_OUT:  if (out_ready) state_next = RVM_OPF_IDLE;
            default:      state_next = RVM_OPF_IDLE;
        endcase
        if (flush) state_next = RVM_OPF_IDLE;
    end

    // State register, request latch and operand capture
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!resetn) begin
            state     <= RVM_OPF_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            use_imm_q <= 1'b0;
            use_pc_q  <= 1'b0;
            op_q      <= RVM_ARITH_NOP;
            lhs       <= '0;
            rhs       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rs1_q     <= in_rs1;
                rs2_q     <= in_rs2;
                imm_q     <= in_imm;
                pc_q      <= in_pc;
                use_imm_q <= in_use_imm;
                use_pc_q  <= in_use_pc;
                op_q      <= in_op;
            end
            // rf_rdata in RS2 answers the rs1 read issued in RS1
            if (!flush && state == RVM_OPF_RS2)
                lhs <= use_pc_q ? pc_q : ((rs1_q == '0) ? '0 : rs1_data);
            // rf_rdata in CAP answers the rs2 read issued in RS2
            if (!flush && state == RVM_OPF_CAP)
                rhs <= use_imm_q ? imm_q : ((rs2_q == '0) ? '0 : rs2_data);
        end
    end

endmodule
